// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared constants and types for the nibble-serial adder
// Purpose: nibble width, FSM state encoding and nibble-index width helper.
// Ports: none (package).
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_width(input int n_nibbles);
    return (n_nibbles > 1) ? $clog2(n_nibbles) : 1;
  endfunction

endpackage

// File: rtl/bit_4.sv
// rtl/bit_4.sv - 4-bit ripple-carry adder
// Purpose: combinational A + B + cin built from a chain of full adders.
// Ports:
//   A, B  in  4  addends
//   cin   in  1  carry in
//   S     out 4  sum
//   cout  out 1  carry out
module bit_4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    S      = '0;
    w_c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      S[i]     = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    cout = w_c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit adder reusing one bit_4, one nibble per clock
// Purpose: start/busy/done multi-cycle adder, LSB nibble first.
// Ports:
//   clk, rst    in   1  clock, async active-high reset
//   start       in   1  request, accepted only when idle
//   a, b        in   W  operands, latched with an accepted start
//   cin         in   1  carry into the LSB nibble
//   busy        out  1  addition in progress
//   done        out  1  one-cycle completion pulse
//   sum         out  W  result, held until the next completion
//   cout, ovf   out  1  carry out and two's-complement overflow
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NIB_W*N_NIBBLES-1:0] a,
  input  logic [NIB_W*N_NIBBLES-1:0] b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [NIB_W*N_NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int W     = NIB_W * N_NIBBLES;
  localparam int IDX_W = idx_width(N_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic [W-1:0]       r_res;
  logic               r_carry;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_done;
  logic [NIB_W-1:0]   w_nib_s;
  logic               w_nib_cout;
  logic [W-1:0]       w_res_nxt;

  bit_4 u_bit_4 (
    .A    (r_op_a[NIB_W-1:0]),
    .B    (r_op_b[NIB_W-1:0]),
    .cin  (r_carry),
    .S    (w_nib_s),
    .cout (w_nib_cout)
  );

  // Each nibble sum enters at the top so the first (LSB) nibble ends at bit 0.
  assign w_res_nxt = {w_nib_s, r_res[W-1:NIB_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_op_a   <= a;
        r_op_b   <= b;
        r_carry  <= cin;
        r_sign_a <= a[W-1];
        r_sign_b <= b[W-1];
        r_idx    <= '0;
      end else if (r_state == RUN) begin
        r_op_a  <= {{NIB_W{1'b0}}, r_op_a[W-1:NIB_W]};
        r_op_b  <= {{NIB_W{1'b0}}, r_op_b[W-1:NIB_W]};
        r_res   <= w_res_nxt;
        r_carry <= w_nib_cout;
        r_idx   <= r_idx + IDX_W'(1);
      end
      // Published outputs only move on the final nibble so the previous
      // result stays visible throughout RUN.
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= w_nib_cout;
        r_ovf  <= (r_sign_a == r_sign_b) && (w_nib_s[NIB_W-1] != r_sign_a);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.N_NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: full-width arithmetic result, released N edges after acceptance.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;
  logic [W:0]   p_tot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
          m_done = 1'b1;
        end
      end else if (start) begin
        p_tot  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        p_sum  = p_tot[W-1:0];
        p_cout = p_tot[W];
        p_ovf  = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
        m_cnt  = N;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({busy, done, cout, ovf, sum} !== {(m_cnt > 0), m_done, m_cout, m_ovf, m_sum}) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual busy=%b done=%b cout=%b ovf=%b sum=%h required busy=%b done=%b cout=%b ovf=%b sum=%h",
                 $time, busy, done, cout, ovf, sum, (m_cnt > 0), m_done, m_cout, m_ovf, m_sum);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    int bc;
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      tick;
      n++;
    end
    chk({name, "_latency"}, n, N);
    chk({name, "_busy_cycles"}, bc, N);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eo);
    tick;
    chk({name, "_done_single"}, done, 0);
  endtask

  initial begin
    int n;
    int dc;

    tick;
    tick;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    tick;

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3a", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // start while busy is ignored
    a = 16'h0005; b = 16'h0006; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    tick;
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dc++;
        chk("t4_sum", sum, 16'h000B);
      end
      tick;
    end
    chk("t4_done_count", dc, 1);

    // reset in the second RUN cycle
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_cout", cout, 0);
    chk("t5_rst_ovf", ovf, 0);
    tick;
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < N + 3; i++) begin
      if (done === 1'b1) dc++;
      tick;
    end
    chk("t5_no_done", dc, 0);
    run_op("t5b", 16'h0003, 16'h0002, 1'b1, 16'h0006, 1'b0, 1'b0);

    // back-to-back start in the done cycle
    a = 16'h000E; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("t6_first_latency", n, N);
    chk("t6_first_sum", sum, 16'h000F);
    a = 16'h0001; b = 16'h000F; start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      chk("t6_sum_hold", sum, 16'h000F);
      tick;
      n++;
    end
    chk("t6_gap", n, N + 1);
    chk("t6_second_sum", sum, 16'h0010);
    chk("t6_second_cout", cout, 0);
    tick;

    // random traffic, including starts while busy and boundary operands
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 16'hFFFF;
        1: b = 16'h7FFF;
        default: b = W'($urandom);
      endcase
      cin = 1'($urandom);
      tick;
    end
    start = 1'b0;
    repeat (N + 3) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
